rob_commit: RTL

ROB_COMMIT -- requirements
Module: rob_commit

---
 rtl/tomasulo_pkg.sv | 35 +++
 rtl/rob_commit_if.sv | 45 ++++
 rtl/rob_entry_file.sv | 56 +++++
 rtl/rob_commit.sv | 96 +++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared ROB/Tomasulo constants, entry layout and opcode helpers.
package tomasulo_pkg;
  localparam int ROB_DEPTH = 8;
  localparam int TAG_W     = 3;
  localparam int DATA_W    = 16;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_LOAD  = 4'b0100;
  localparam logic [3:0] OP_STORE = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_BNEQ  = 4'b0111;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] func;
    logic [3:0] rd;
    logic [7:0] addr;
    data_t      value;
  } rob_entry_t;

  function automatic logic writes_reg(input logic [3:0] f);
    return f <= OP_LOAD;
  endfunction

  function automatic logic is_branch(input logic [3:0] f);
    return (f == OP_BEQ) || (f == OP_BNEQ);
  endfunction
endpackage

// File: rtl/rob_commit_if.sv
// Issue / CDB / retire bundle between the pipeline and the ROB.
interface rob_commit_if;
  import tomasulo_pkg::*;

  logic       alloc_valid;
  logic [3:0] alloc_func;
  logic [3:0] alloc_rd;
  logic [7:0] alloc_addr;
  logic       alloc_ready;
  tag_t       alloc_tag;

  logic       cdb_valid;
  tag_t       cdb_tag;
  data_t      cdb_data;

  logic       commit_we;
  logic [3:0] commit_rd;
  data_t      commit_data;
  tag_t       commit_tag;

  logic       mem_we;
  logic [7:0] mem_addr;
  data_t      mem_wdata;

  logic       flush;
  logic [3:0] flush_pc;

  modport master (
    output alloc_valid, alloc_func, alloc_rd, alloc_addr,
    output cdb_valid, cdb_tag, cdb_data,
    input  alloc_ready, alloc_tag,
    input  commit_we, commit_rd, commit_data, commit_tag,
    input  mem_we, mem_addr, mem_wdata,
    input  flush, flush_pc
  );

  modport slave (
    input  alloc_valid, alloc_func, alloc_rd, alloc_addr,
    input  cdb_valid, cdb_tag, cdb_data,
    output alloc_ready, alloc_tag,
    output commit_we, commit_rd, commit_data, commit_tag,
    output mem_we, mem_addr, mem_wdata,
    output flush, flush_pc
  );
endinterface

// File: rtl/rob_entry_file.sv
// ROB entry storage: allocate, CDB writeback and retire write ports.
module rob_entry_file
  import tomasulo_pkg::*;
(
  input  logic       clk1,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       alloc_en,
  input  tag_t       alloc_idx,
  input  logic [3:0] alloc_func,
  input  logic [3:0] alloc_rd,
  input  logic [7:0] alloc_addr,
  input  logic       cdb_valid,
  input  tag_t       cdb_tag,
  input  data_t      cdb_data,
  input  logic       retire_en,
  input  tag_t       retire_idx,
  input  tag_t       rd_idx,
  output rob_entry_t rd_entry
);
  rob_entry_t ent [ROB_DEPTH];

  // later assignments win: retire over CDB, allocate over both
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_DEPTH; i++)
        ent[i] <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (flush) begin
          ent[i].busy <= 1'b0;
          ent[i].done <= 1'b0;
        end else begin
          if (cdb_valid && cdb_tag == tag_t'(i)
              && ent[i].busy) begin
            ent[i].done  <= 1'b1;
            ent[i].value <= cdb_data;
          end
          if (retire_en && retire_idx == tag_t'(i)) begin
            ent[i].busy <= 1'b0;
            ent[i].done <= 1'b0;
          end
          if (alloc_en && alloc_idx == tag_t'(i)) begin
            ent[i].busy <= 1'b1;
            ent[i].done <= 1'b0;
            ent[i].func <= alloc_func;
            ent[i].rd   <= alloc_rd;
            ent[i].addr <= alloc_addr;
          end
        end
      end
    end
  end

  assign rd_entry = ent[rd_idx];
endmodule

// File: rtl/rob_commit.sv
// In-order ROB: pointers, occupancy and single-slot retire/flush.
module rob_commit
  import tomasulo_pkg::*;
(
  input logic         clk1,
  input logic         rst_n,
  rob_commit_if.slave bus
);
  localparam logic [3:0] FULL = 4'(ROB_DEPTH);

  tag_t       head_p;
  tag_t       tail_p;
  logic [3:0] count;
  rob_entry_t head_e;
  logic       alloc_fire;
  logic       commit_fire;
  logic       taken;
  logic       wr_reg;
  logic       wr_mem;

  assign bus.alloc_ready = (count < FULL);
  assign bus.alloc_tag   = tail_p;

  assign commit_fire = head_e.busy && head_e.done;
  assign wr_reg      = commit_fire && writes_reg(head_e.func);
  assign wr_mem      = commit_fire && (head_e.func == OP_STORE);
  assign taken       = commit_fire && is_branch(head_e.func)
                       && head_e.value[0];
  // a taken branch wipes the ROB, so a same-cycle allocation is dropped
  assign alloc_fire  = bus.alloc_valid && bus.alloc_ready && !taken;

  rob_entry_file u_file (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .flush      (taken),
    .alloc_en   (alloc_fire),
    .alloc_idx  (tail_p),
    .alloc_func (bus.alloc_func),
    .alloc_rd   (bus.alloc_rd),
    .alloc_addr (bus.alloc_addr),
    .cdb_valid  (bus.cdb_valid),
    .cdb_tag    (bus.cdb_tag),
    .cdb_data   (bus.cdb_data),
    .retire_en  (commit_fire),
    .retire_idx (head_p),
    .rd_idx     (head_p),
    .rd_entry   (head_e)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      head_p <= '0;
      tail_p <= '0;
      count  <= '0;
    end else if (taken) begin
      head_p <= '0;
      tail_p <= '0;
      count  <= '0;
    end else begin
      if (alloc_fire)
        tail_p <= tail_p + tag_t'(1);
      if (commit_fire)
        head_p <= head_p + tag_t'(1);
      count <= count + 4'(alloc_fire) - 4'(commit_fire);
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      bus.commit_we   <= 1'b0;
      bus.commit_rd   <= '0;
      bus.commit_data <= '0;
      bus.commit_tag  <= '0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.flush       <= 1'b0;
      bus.flush_pc    <= '0;
    end else begin
      bus.commit_we <= wr_reg;
      bus.mem_we    <= wr_mem;
      bus.flush     <= taken;
      if (wr_reg) begin
        bus.commit_rd   <= head_e.rd;
        bus.commit_data <= head_e.value;
        bus.commit_tag  <= head_p;
      end
      if (wr_mem) begin
        bus.mem_addr  <= head_e.addr;
        bus.mem_wdata <= head_e.value;
      end
      if (taken)
        bus.flush_pc <= head_e.rd;
    end
  end
endmodule
